// File: rtl/t2mi_pkg.sv
// Shared constants and FSM encoding for the T2-MI transport stream monitor.
package t2mi_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam int          TS_PKT_LEN   = 188;
    localparam logic [12:0] NULL_PID     = 13'h1FFF;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    function automatic logic [3:0] cc_next(input logic [3:0] cc);
        return cc + 4'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/t2mi_ts_monitor.sv
// TS packet alignment, header parse and CC monitor for the T2-MI PID.
// Statistics counters exist only when T2MI_MON_STATS_EN is defined.
module t2mi_ts_monitor
    import t2mi_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int LOCK_N = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       DATA_IN,
    input  logic             DVALID_IN,
    input  logic             PSYNC_IN,
    input  logic [12:0]      MON_PID,
    input  logic             CLR,
    output logic             LOCKED,
    output logic             ERR_PULSE,
    output logic [CNT_W-1:0] PKT_CNT,
    output logic [CNT_W-1:0] PID_PKT_CNT,
    output logic [CNT_W-1:0] CC_ERR_CNT,
    output logic [CNT_W-1:0] SYNC_ERR_CNT,
    output logic [CNT_W-1:0] TEI_CNT
);

    localparam logic [7:0] LAST_IDX = 8'(TS_PKT_LEN - 1);
    localparam logic [7:0] LOCK_CNT = 8'(LOCK_N);

    state_t      r_state;
    logic [7:0]  r_idx;
    logic [7:0]  r_good;
    logic        r_locked;
    logic        r_err;
    logic        r_tei;
    logic [12:0] r_pid;
    logic [12:0] r_mon_q;
    logic [3:0]  r_cc_ref;
    logic        r_cc_vld;

    logic w_good;
    logic w_sync_err;
    logic w_lock_byte;
    logic w_hdr3;
    logic w_mon;
    logic w_cc_chk;
    logic w_cc_err;
    logic w_pkt_inc;
    logic w_pid_inc;
    logic w_tei_inc;
    logic w_sync_inc;

    always_comb begin
        w_good     = PSYNC_IN && (DATA_IN == TS_SYNC_BYTE);
        w_sync_err = 1'b0;
        if (DVALID_IN && r_state != HUNT) begin
            if (r_idx == 8'd0) begin
                w_sync_err = !w_good;
            end else begin
                w_sync_err = PSYNC_IN;
            end
        end
        w_lock_byte = DVALID_IN && (r_state == LOCK) && !w_sync_err;
        w_hdr3      = w_lock_byte && (r_idx == 8'd3);
        w_mon       = (r_pid == MON_PID);
        // AFC bit 4 set means a payload is present (01 or 11)
        w_cc_chk    = w_hdr3 && w_mon && (r_pid != NULL_PID) && DATA_IN[4];
        w_cc_err    = w_cc_chk && r_cc_vld && (r_mon_q == MON_PID)
                      && (DATA_IN[3:0] != cc_next(r_cc_ref));
        w_pkt_inc   = w_lock_byte && (r_idx == LAST_IDX);
        w_pid_inc   = w_hdr3 && w_mon;
        w_tei_inc   = w_hdr3 && r_tei;
        w_sync_inc  = DVALID_IN && (r_state == LOCK) && w_sync_err;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= HUNT;
            r_idx    <= 8'd0;
            r_good   <= 8'd0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_tei    <= 1'b0;
            r_pid    <= 13'd0;
            r_mon_q  <= 13'd0;
            r_cc_ref <= 4'd0;
            r_cc_vld <= 1'b0;
        end else begin
            r_mon_q <= MON_PID;
            r_err   <= w_sync_inc || w_cc_err;
            if (r_mon_q != MON_PID) begin
                r_cc_vld <= 1'b0;
            end
            if (DVALID_IN) begin
                if (r_idx == 8'd1) begin
                    r_tei       <= DATA_IN[7];
                    r_pid[12:8] <= DATA_IN[4:0];
                end
                if (r_idx == 8'd2) begin
                    r_pid[7:0] <= DATA_IN;
                end
                if (w_sync_err || r_state == HUNT) begin
                    // a short-packet byte that is a good sync restarts acquisition
                    r_cc_vld <= 1'b0;
                    if (w_good) begin
                        r_idx    <= 8'd1;
                        r_good   <= 8'd1;
                        r_state  <= (LOCK_N <= 1) ? LOCK : ACQ;
                        r_locked <= (LOCK_N <= 1);
                    end else begin
                        r_idx    <= 8'd0;
                        r_good   <= 8'd0;
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                end else begin
                    r_idx <= (r_idx == LAST_IDX) ? 8'd0 : r_idx + 8'd1;
                    if (r_idx == 8'd0 && r_state == ACQ) begin
                        r_good <= r_good + 8'd1;
                        if (r_good + 8'd1 >= LOCK_CNT) begin
                            r_state  <= LOCK;
                            r_locked <= 1'b1;
                        end
                    end
                    if (w_cc_chk) begin
                        r_cc_ref <= DATA_IN[3:0];
                        r_cc_vld <= 1'b1;
                    end
                end
            end
        end
    end

    assign LOCKED    = r_locked;
    assign ERR_PULSE = r_err;

`ifdef T2MI_MON_STATS_EN
    sat_counter #(.CNT_W(CNT_W)) u_pkt (
        .i_clk(CLK), .i_rst_n(RST), .i_inc(w_pkt_inc),
        .i_clr(CLR), .o_cnt(PKT_CNT)
    );
    sat_counter #(.CNT_W(CNT_W)) u_pid (
        .i_clk(CLK), .i_rst_n(RST), .i_inc(w_pid_inc),
        .i_clr(CLR), .o_cnt(PID_PKT_CNT)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cc (
        .i_clk(CLK), .i_rst_n(RST), .i_inc(w_cc_err),
        .i_clr(CLR), .o_cnt(CC_ERR_CNT)
    );
    sat_counter #(.CNT_W(CNT_W)) u_sync (
        .i_clk(CLK), .i_rst_n(RST), .i_inc(w_sync_inc),
        .i_clr(CLR), .o_cnt(SYNC_ERR_CNT)
    );
    sat_counter #(.CNT_W(CNT_W)) u_tei (
        .i_clk(CLK), .i_rst_n(RST), .i_inc(w_tei_inc),
        .i_clr(CLR), .o_cnt(TEI_CNT)
    );
`else
    logic w_unused;
    assign w_unused = &{1'b0, w_pkt_inc, w_pid_inc, w_tei_inc, CLR};

    assign PKT_CNT      = '0;
    assign PID_PKT_CNT  = '0;
    assign CC_ERR_CNT   = '0;
    assign SYNC_ERR_CNT = '0;
    assign TEI_CNT      = '0;
`endif

endmodule

// File: tb/tb_t2mi_ts_monitor.sv
// Self-checking bench for t2mi_ts_monitor; expected ERR_PULSE cycles go
// through a queue, counters are compared per scenario.
module tb_t2mi_ts_monitor;

`ifdef T2MI_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        dv = 1'b0;
    logic        ps = 1'b0;
    logic        clr = 1'b0;
    logic [12:0] mon = 13'd0;

    logic        locked, errp;
    logic [31:0] pkt, pidc, cce, syn, tei;
    logic        locked4, unused4_err;
    logic [3:0]  unused4_pkt, unused4_pid, unused4_cc, unused4_syn, tei4;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_q[$];

    t2mi_ts_monitor dut (
        .CLK(clk), .RST(rst_n), .DATA_IN(data), .DVALID_IN(dv),
        .PSYNC_IN(ps), .MON_PID(mon), .CLR(clr),
        .LOCKED(locked), .ERR_PULSE(errp),
        .PKT_CNT(pkt), .PID_PKT_CNT(pidc), .CC_ERR_CNT(cce),
        .SYNC_ERR_CNT(syn), .TEI_CNT(tei)
    );

    t2mi_ts_monitor #(.CNT_W(4)) dut4 (
        .CLK(clk), .RST(rst_n), .DATA_IN(data), .DVALID_IN(dv),
        .PSYNC_IN(ps), .MON_PID(mon), .CLR(clr),
        .LOCKED(locked4), .ERR_PULSE(unused4_err),
        .PKT_CNT(unused4_pkt), .PID_PKT_CNT(unused4_pid),
        .CC_ERR_CNT(unused4_cc), .SYNC_ERR_CNT(unused4_syn),
        .TEI_CNT(tei4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ex(input int n);
        return STATS ? n : 0;
    endfunction

    // ERR_PULSE scoreboard: every pulse must match the next expected cycle
    always @(negedge clk) begin
        if (errp === 1'b1) begin
            int e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL err_pulse_unexpected got=pulse@%0d exp=none", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e != cyc) begin
                    bad++;
                    $display("FAIL err_pulse_cycle got=%0d exp=%0d", cyc, e);
                end
            end
        end
    end

    task automatic send_pkt(
        input logic [12:0] pid, input logic [3:0] cc, input logic t,
        input logic [7:0] sb, input logic [1:0] afc,
        input int first, input int last, input bit gap,
        input bit e_sync, input bit e_cc, input int clr_idx,
        output logic lk
    );
        lk = locked;
        for (int i = first; i <= last; i++) begin
            dv  = 1'b1;
            clr = (i == clr_idx);
            ps  = (i == 0);
            case (i)
                0:       data = sb;
                1:       data = {t, 2'b00, pid[12:8]};
                2:       data = pid[7:0];
                3:       data = {2'b00, afc, cc};
                default: data = 8'(i);
            endcase
            @(posedge clk);
            #1;
            if (i == 0) begin
                lk = locked;
                if (e_sync) exp_q.push_back(cyc);
            end
            if (i == 3 && e_cc) exp_q.push_back(cyc);
            clr = 1'b0;
            if (gap) begin
                dv   = 1'b0;
                ps   = 1'b1;
                data = 8'h47;
                @(posedge clk);
                #1;
            end
        end
        dv = 1'b0;
        ps = 1'b0;
    endtask

    task automatic pkt_ok(input logic [12:0] pid, input logic [3:0] cc,
                          input bit gap, output logic lk);
        send_pkt(pid, cc, 1'b0, 8'h47, 2'b01, 0, 187, gap, 0, 0, -1, lk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dv = 1'b0; ps = 1'b0; data = 8'd0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dv = 1'b1; ps = 1'b1; data = 8'h47; mon = 13'd4096;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (locked !== 1'b0) begin
            bad++; $display("FAIL rst_locked got=%b exp=0", locked);
        end
        total++;
        if (errp !== 1'b0) begin
            bad++; $display("FAIL rst_err got=%b exp=0", errp);
        end
        total++;
        if ({pkt, pidc, cce, syn, tei} !== 160'd0) begin
            bad++; $display("FAIL rst_counters got=%h exp=0", {pkt, pidc, cce, syn, tei});
        end
        dv = 1'b0; ps = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_clean(input bit gap);
        logic lk;
        do_reset();
        mon = 13'd4096;
        pkt_ok(13'd4096, 4'd0, gap, lk);
        pkt_ok(13'd4096, 4'd1, gap, lk);
        total++;
        if (locked !== 1'b0) begin
            bad++; $display("FAIL clean_lock_early gap=%0d got=%b exp=0", gap, locked);
        end
        pkt_ok(13'd4096, 4'd2, gap, lk);
        total++;
        if (lk !== 1'b1) begin
            bad++; $display("FAIL clean_lock_time gap=%0d got=%b exp=1", gap, lk);
        end
        pkt_ok(13'd4096, 4'd3, gap, lk);
        pkt_ok(13'd4096, 4'd4, gap, lk);
        total++;
        if (pkt !== 32'(ex(3))) begin
            bad++; $display("FAIL clean_pkt gap=%0d got=%0d exp=%0d", gap, pkt, ex(3));
        end
        total++;
        if (pidc !== 32'(ex(3))) begin
            bad++; $display("FAIL clean_pid gap=%0d got=%0d exp=%0d", gap, pidc, ex(3));
        end
        total++;
        if ({cce, syn, tei} !== 96'd0) begin
            bad++; $display("FAIL clean_errs gap=%0d got=%h exp=0", gap, {cce, syn, tei});
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL clean_pulses got=%0d_missing exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_sync_err();
        logic lk;
        do_reset();
        mon = 13'd4096;
        for (int i = 0; i < 3; i++) pkt_ok(13'd4096, 4'(i), 1'b0, lk);
        send_pkt(13'd4096, 4'd3, 1'b0, 8'h00, 2'b01, 0, 187, 0, 1, 0, -1, lk);
        total++;
        if (locked !== 1'b0) begin
            bad++; $display("FAIL sync_unlock got=%b exp=0", locked);
        end
        total++;
        if (syn !== 32'(ex(1))) begin
            bad++; $display("FAIL sync_cnt got=%0d exp=%0d", syn, ex(1));
        end
        pkt_ok(13'd4096, 4'd4, 1'b0, lk);
        pkt_ok(13'd4096, 4'd5, 1'b0, lk);
        total++;
        if (locked !== 1'b0) begin
            bad++; $display("FAIL sync_relock_early got=%b exp=0", locked);
        end
        pkt_ok(13'd4096, 4'd6, 1'b0, lk);
        total++;
        if (lk !== 1'b1) begin
            bad++; $display("FAIL sync_relock got=%b exp=1", lk);
        end
        total++;
        if ({pkt, syn, cce} !== {32'(ex(2)), 32'(ex(1)), 32'd0}) begin
            bad++; $display("FAIL sync_final got=%0d/%0d/%0d exp=%0d/%0d/0", pkt, syn, cce, ex(2), ex(1));
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL sync_pulses got=%0d_missing exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_cc();
        logic lk;
        logic [3:0] seq [6];
        logic [3:0] nul [4];
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
        nul = '{4'd5, 4'd9, 4'd0, 4'd13};
        do_reset();
        mon = 13'd4096;
        for (int i = 0; i < 6; i++)
            send_pkt(13'd4096, seq[i], 1'b0, 8'h47, 2'b01, 0, 187, 0, 0, (i == 4), -1, lk);
        total++;
        if (cce !== 32'(ex(1))) begin
            bad++; $display("FAIL cc_err_cnt got=%0d exp=%0d", cce, ex(1));
        end
        mon = 13'h1FFF;
        for (int i = 0; i < 4; i++)
            send_pkt(13'h1FFF, nul[i], 1'b0, 8'h47, 2'b11, 0, 187, 0, 0, 0, -1, lk);
        mon = 13'd4096;
        pkt_ok(13'd4096, 4'd10, 1'b0, lk);
        pkt_ok(13'd4096, 4'd11, 1'b0, lk);
        send_pkt(13'd4096, 4'd11, 1'b0, 8'h47, 2'b10, 0, 187, 0, 0, 0, -1, lk);
        pkt_ok(13'd4096, 4'd12, 1'b0, lk);
        total++;
        if (cce !== 32'(ex(1))) begin
            bad++; $display("FAIL cc_no_extra got=%0d exp=%0d", cce, ex(1));
        end
        total++;
        if ({pkt, pidc} !== {32'(ex(12)), 32'(ex(12))}) begin
            bad++; $display("FAIL cc_counts got=%0d/%0d exp=%0d/%0d", pkt, pidc, ex(12), ex(12));
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL cc_pulses got=%0d_missing exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_short();
        logic lk;
        do_reset();
        mon = 13'd4096;
        for (int i = 0; i < 3; i++) pkt_ok(13'd4096, 4'(i), 1'b0, lk);
        send_pkt(13'd4096, 4'd3, 1'b0, 8'h47, 2'b01, 0, 99, 0, 0, 0, -1, lk);
        send_pkt(13'd4096, 4'd4, 1'b0, 8'h47, 2'b01, 0, 187, 0, 1, 0, -1, lk);
        total++;
        if (lk !== 1'b0) begin
            bad++; $display("FAIL short_unlock got=%b exp=0", lk);
        end
        pkt_ok(13'd4096, 4'd5, 1'b0, lk);
        total++;
        if (locked !== 1'b0) begin
            bad++; $display("FAIL short_early got=%b exp=0", locked);
        end
        pkt_ok(13'd4096, 4'd6, 1'b0, lk);
        total++;
        if (lk !== 1'b1) begin
            bad++; $display("FAIL short_reacq got=%b exp=1", lk);
        end
        total++;
        if ({pkt, syn} !== {32'(ex(2)), 32'(ex(1))}) begin
            bad++; $display("FAIL short_counts got=%0d/%0d exp=%0d/%0d", pkt, syn, ex(2), ex(1));
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL short_pulses got=%0d_missing exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_sat_clr();
        logic lk;
        do_reset();
        mon = 13'd4096;
        for (int i = 0; i < 20; i++)
            send_pkt(13'd4096, 4'(i), 1'b1, 8'h47, 2'b01, 0, 187, 0, 0, 0, -1, lk);
        total++;
        if (tei4 !== 4'(ex(15))) begin
            bad++; $display("FAIL sat_tei4 got=%0d exp=%0d", tei4, ex(15));
        end
        total++;
        if (tei !== 32'(ex(18))) begin
            bad++; $display("FAIL sat_tei32 got=%0d exp=%0d", tei, ex(18));
        end
        send_pkt(13'd4096, 4'd4, 1'b1, 8'h47, 2'b01, 0, 187, 0, 0, 0, 3, lk);
        total++;
        if ({tei, pidc, tei4} !== 68'd0) begin
            bad++; $display("FAIL clr_prio got=%0d/%0d/%0d exp=0/0/0", tei, pidc, tei4);
        end
        total++;
        if (pkt !== 32'(ex(1))) begin
            bad++; $display("FAIL clr_pkt got=%0d exp=%0d", pkt, ex(1));
        end
        total++;
        if ({locked, locked4} !== 2'b11) begin
            bad++; $display("FAIL clr_fsm got=%b%b exp=11", locked, locked4);
        end
    endtask

    task automatic test_rst_mid();
        logic lk;
        do_reset();
        mon = 13'd4096;
        for (int i = 0; i < 3; i++) pkt_ok(13'd4096, 4'(i), 1'b0, lk);
        send_pkt(13'd4096, 4'd3, 1'b0, 8'h47, 2'b01, 0, 49, 0, 0, 0, -1, lk);
        total++;
        if ({locked, pkt} !== {1'b1, 32'(ex(1))}) begin
            bad++; $display("FAIL rstmid_pre got=%b/%0d exp=1/%0d", locked, pkt, ex(1));
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({locked, errp, pkt, pidc, cce, syn, tei} !== 162'd0) begin
            bad++; $display("FAIL rstmid_async got=%b/%b/%0d/%0d exp=0/0/0/0", locked, errp, pkt, pidc);
        end
        #1 rst_n = 1'b1;
        send_pkt(13'd4096, 4'd3, 1'b0, 8'h47, 2'b01, 50, 187, 0, 0, 0, -1, lk);
        pkt_ok(13'd4096, 4'd4, 1'b0, lk);
        pkt_ok(13'd4096, 4'd5, 1'b0, lk);
        total++;
        if (locked !== 1'b0) begin
            bad++; $display("FAIL rstmid_early got=%b exp=0", locked);
        end
        pkt_ok(13'd4096, 4'd6, 1'b0, lk);
        total++;
        if (lk !== 1'b1) begin
            bad++; $display("FAIL rstmid_relock got=%b exp=1", lk);
        end
        total++;
        if (pkt !== 32'(ex(1))) begin
            bad++; $display("FAIL rstmid_pkt got=%0d exp=%0d", pkt, ex(1));
        end
    endtask

    initial begin
        test_reset();
        test_clean(1'b0);
        test_clean(1'b1);
        test_sync_err();
        test_cc();
        test_short();
        test_sat_clr();
        test_rst_mid();
        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
